// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - funct3 codes, FSM state type and store byte-enable helper for dmem_resp
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} dmem_state_t;

  // Anything that is not byte or half is written as a full word.
  function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] offset);
    logic [3:0] be;
    case (funct3)
      F3_B:    be = 4'b0001 << offset;
      F3_H:    be = offset[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// rtl/dmem_load_ext.sv - extracts the addressed byte/half/word and sign- or zero-extends it
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{offset, 3'b000} +: 8];
    lane_h = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   data = {24'd0, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   data = {16'd0, lane_h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - handshaked RV32I data-memory responder with programmable wait states
// Optional access-error checking is enabled by defining DMEM_RESP_ERR_EN.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IW = $clog2(DEPTH_WORDS);

  dmem_state_t state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        accept, mem_we;

  logic        r_we;
  logic [31:0] r_addr, r_wdata;
  logic [2:0]  r_funct3;

  logic [31:0] mem [DEPTH_WORDS];
  logic [IW-1:0] idx;
  logic [1:0]  offset;
  logic        acc_err;
  logic [3:0]  be;
  logic [31:0] st_data, rd_word, ld_data;

  assign idx    = r_addr[2 +: IW];
  assign offset = r_addr[1:0];

`ifdef DMEM_RESP_ERR_EN
  always_comb begin
    acc_err = 1'b0;
    case (r_funct3)
      F3_B:    acc_err = 1'b0;
      F3_H:    acc_err = r_addr[0];
      F3_W:    acc_err = |r_addr[1:0];
      F3_BU:   acc_err = r_we;
      F3_HU:   acc_err = r_we | r_addr[0];
      default: acc_err = 1'b1;
    endcase
    if ((r_addr >> (IW + 2)) != 32'd0)
      acc_err = 1'b1;
  end
`else
  // Half/word lane selection only looks at the relevant offset bits, so
  // misaligned accesses align down and upper address bits simply wrap.
  assign acc_err = 1'b0;
  logic unused_addr_hi;
  assign unused_addr_hi = ^r_addr[31:IW+2];
`endif

  assign be      = store_be(r_funct3, offset);
  assign rd_word = mem[idx];

  always_comb begin
    case (r_funct3)
      F3_B:    st_data = {4{r_wdata[7:0]}};
      F3_H:    st_data = {2{r_wdata[15:0]}};
      default: st_data = r_wdata;
    endcase
  end

  dmem_load_ext u_load_ext (
    .word   (rd_word),
    .offset (offset),
    .funct3 (r_funct3),
    .data   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !reset;
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_next = WAIT;
            cnt_next   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_next = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_next = ACCESS;
        else             cnt_next   = cnt - 4'd1;
      end
      ACCESS: begin
        mem_we     = r_we && !acc_err && !reset;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = !reset;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we      <= 1'b0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_funct3  <= 3'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        r_we     <= req_we;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_funct3 <= req_funct3;
      end
      if (state == ACCESS) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (r_we || acc_err) ? 32'd0 : ld_data;
      end
    end
  end

  // Storage has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Handshaked data-memory responder: the memory-side end of the core's load/store port.
- Accepts one load/store request at a time, applies RV32I byte/half/word lane rules, sign/zero-extends load data, and returns a response after a configurable number of wait states.
- Replaces the zero-latency data memory when the core moves to a multicycle/stallable memory interface.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words of storage. Index width is clog2(DEPTH_WORDS).
- WAIT_CYCLES, 0: extra stall cycles inserted between accept and access, 0..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- req_funct3  in  3  RV32I funct3 (S: 000 SB, 001 SH, 010 SW; L: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access error flag, qualified by rsp_valid.

Behaviour:
- Reset values: req_ready=0 during the reset cycle, then 1 in IDLE. rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, wait counter=0.
- Reset does not clear storage contents.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch we/addr/wdata/funct3. Go to WAIT (counter=WAIT_CYCLES-1) if WAIT_CYCLES>0, else to ACCESS.
  - WAIT: req_ready=0. Decrement the counter; go to ACCESS when it reaches 0.
  - ACCESS: req_ready=0, one cycle.
    - Store: byte lanes commit at the end of the cycle.
    - Load: the addressed word is read, extracted and extended into the rsp_rdata register.
    - Error status is registered into rsp_err. Go to RESP.
  - RESP: rsp_valid=1, rsp_rdata/rsp_err held stable. On rsp_ready, go to IDLE; rsp_valid drops the next cycle.
- Latency: request accepted at edge N; rsp_valid is first high in the cycle after edge N+1+WAIT_CYCLES. With rsp_ready tied 1, a new request is accepted every 3+WAIT_CYCLES cycles.
- req_ready is never high outside IDLE. A request held on the bus while busy is ignored until IDLE.
- Addressing: word index = req_addr[2 +: clog2(DEPTH_WORDS)]; byte offset = req_addr[1:0].
- SB writes wdata[7:0] to the lane selected by offset.
- SH writes wdata[15:0] to the half selected by addr[1].
- SW writes all 4 lanes.
- Unwritten lanes are preserved.
- LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW returns the full word.
- Reset asserted in WAIT or ACCESS: the request is dropped and no write occurs. Reset in RESP drops the pending response.
- rsp_ready high outside RESP has no effect.

Optional Feature:
- Macro: DMEM_RESP_ERR_EN.
- Defined:
  - rsp_err=1 for a misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0), an address whose word index is ≥ DEPTH_WORDS (upper bits nonzero), or funct3 011/110/111 (load) / 011–111 (store).
  - On error the store is suppressed and rsp_rdata=0.
- Undefined:
  - rsp_err tied 0.
  - Misaligned accesses are aligned down (SH/LH ignore addr[0]; SW/LW ignore addr[1:0]).
  - Upper address bits are ignored, so the address wraps modulo DEPTH_WORDS*4.
  - Illegal funct3 is treated as word width.

Decomposition:
- Package dmem_pkg:
  - funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - State enum typedef dmem_state_t {IDLE, WAIT, ACCESS, RESP}.
  - Function for byte-enable generation from funct3 and offset.
- Sub-module dmem_load_ext: combinational word + offset + funct3 → extended 32-bit load data. Instantiated once in the ACCESS path.

Test Plan:
- Reset, then SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0. rsp_valid first high 2 cycles after accept with WAIT_CYCLES=0, and 5 cycles after with WAIT_CYCLES=3.
- After the above, SB addr 0x13 wdata 0x000000A5, then LW 0x10 → 0xA5ADBEEF.
  - LB 0x13 → 0xFFFFFFA5; LBU 0x13 → 0x000000A5.
  - LH 0x12 → 0xFFFFA5AD; LHU 0x12 → 0x0000A5AD.
- Backpressure: hold rsp_ready=0 for 4 cycles in RESP → rsp_valid/rsp_rdata stable, req_ready=0, and a second req_valid is not accepted until one cycle after the rsp_ready handshake.
- Reset pulsed in ACCESS of SW 0x20 wdata 0x12345678 → no response. A following LW 0x20 returns the prior contents (0x00000000 from a zeroed init).
- With DMEM_RESP_ERR_EN: SW addr 0x22 → rsp_err=1 and memory unchanged; LW addr 0x400 (DEPTH_WORDS=256) → rsp_err=1, rsp_rdata=0.
- Without DMEM_RESP_ERR_EN: LW 0x22 returns word 0x20 with rsp_err=0.
